// File: rtl/fetch_queue.sv
// Dual-lane instruction fetch stage: owns the fetch PCs, issues one synchronous
// read per lane per cycle and queues returned words with their PCs for decode.

module FetchLane #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              redir,
    input  logic [ADDR_W-1:0] redirPc,
    output logic              memEn,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [31:0]       memDout,
    output logic              instrValid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instrPc,
    input  logic              instrReady
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] infPc;
    logic              inf;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       dataMem [DEPTH];
    logic [ADDR_W-1:0] pcMem [DEPTH];

    logic              flush;
    logic              pop;
    logic              push;
    logic [CNT_W:0]    occupancy;

    // Issue only when a FIFO slot is guaranteed for the returning word, so the
    // queue can never overflow; an inactive lane behaves as a permanent flush.
    always_comb begin
        flush      = redir || !active;
        instrValid = (count != '0);
        pop        = instrValid && instrReady;
        push       = inf && !flush;
        occupancy  = {1'b0, count} + (CNT_W+1)'(inf) - (CNT_W+1)'(pop);
        memEn      = active && !rst && !redir && (occupancy < (CNT_W+1)'(DEPTH));
        memAddr    = fpc + ADDR_W'(BASE);
        instr      = instrValid ? dataMem[rdPtr] : '0;
        instrPc    = instrValid ? pcMem[rdPtr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc   <= '0;
            infPc <= '0;
            inf   <= 1'b0;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            inf   <= 1'b0;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            if (redir) begin
                fpc <= redirPc;
            end
        end else begin
            inf <= memEn;
            if (memEn) begin
                infPc <= fpc;
                fpc   <= fpc + ADDR_W'(1);
            end
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage carries no reset; outputs are masked by instrValid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            dataMem[wrPtr] <= memDout;
            pcMem[wrPtr]   <= infPc;
        end
    end

endmodule

module fetch_queue #(
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 32,
    parameter int LANE_B_BASE = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    output logic              imem_en_a,
    output logic [ADDR_W-1:0] imem_addr_a,
    input  logic [31:0]       imem_dout_a,
    output logic              imem_en_b,
    output logic [ADDR_W-1:0] imem_addr_b,
    input  logic [31:0]       imem_dout_b,
    input  logic              redir_a,
    input  logic              redir_b,
    input  logic [ADDR_W-1:0] redir_pc_a,
    input  logic [ADDR_W-1:0] redir_pc_b,
    output logic              instr_valid_a,
    output logic              instr_valid_b,
    output logic [31:0]       instr_a,
    output logic [31:0]       instr_b,
    output logic [ADDR_W-1:0] instr_pc_a,
    output logic [ADDR_W-1:0] instr_pc_b,
    input  logic              instr_ready_a,
    input  logic              instr_ready_b
);

    logic              modeQ;
    logic              modeChange;
    logic              laneBActive;
    logic              redirA;
    logic              redirB;
    logic [ADDR_W-1:0] redirPcA;
    logic [ADDR_W-1:0] redirPcB;

    always_ff @(posedge clk) begin
        modeQ <= mode;
    end

    // A mode switch restarts both lanes from PC 0 as if both were redirected.
    always_comb begin
        modeChange  = (mode != modeQ);
        laneBActive = !mode;
        redirA      = redir_a || modeChange;
        redirB      = (laneBActive && redir_b) || modeChange;
        redirPcA    = modeChange ? '0 : redir_pc_a;
        redirPcB    = modeChange ? '0 : redir_pc_b;
    end

    FetchLane #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .BASE  (0)
    ) laneA (
        .clk       (clk),
        .rst       (rst),
        .active    (1'b1),
        .redir     (redirA),
        .redirPc   (redirPcA),
        .memEn     (imem_en_a),
        .memAddr   (imem_addr_a),
        .memDout   (imem_dout_a),
        .instrValid(instr_valid_a),
        .instr     (instr_a),
        .instrPc   (instr_pc_a),
        .instrReady(instr_ready_a)
    );

    FetchLane #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .BASE  (LANE_B_BASE)
    ) laneB (
        .clk       (clk),
        .rst       (rst),
        .active    (laneBActive),
        .redir     (redirB),
        .redirPc   (redirPcB),
        .memEn     (imem_en_b),
        .memAddr   (imem_addr_b),
        .memDout   (imem_dout_b),
        .instrValid(instr_valid_b),
        .instr     (instr_b),
        .instrPc   (instr_pc_b),
        .instrReady(instr_ready_b)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a synchronous memory model returns
// 0x1000_0000+addr on lane A and 0x2000_0000+addr on lane B.

module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        imem_en_a;
    logic [31:0] imem_addr_a;
    logic [31:0] imem_dout_a;
    logic        imem_en_b;
    logic [31:0] imem_addr_b;
    logic [31:0] imem_dout_b;
    logic        redir_a;
    logic        redir_b;
    logic [31:0] redir_pc_a;
    logic [31:0] redir_pc_b;
    logic        instr_valid_a;
    logic        instr_valid_b;
    logic [31:0] instr_a;
    logic [31:0] instr_b;
    logic [31:0] instr_pc_a;
    logic [31:0] instr_pc_b;
    logic        instr_ready_a;
    logic        instr_ready_b;

    int vectors;
    int miscompares;
    int enCount;
    int expA;
    int expB;

    fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .imem_en_a    (imem_en_a),
        .imem_addr_a  (imem_addr_a),
        .imem_dout_a  (imem_dout_a),
        .imem_en_b    (imem_en_b),
        .imem_addr_b  (imem_addr_b),
        .imem_dout_b  (imem_dout_b),
        .redir_a      (redir_a),
        .redir_b      (redir_b),
        .redir_pc_a   (redir_pc_a),
        .redir_pc_b   (redir_pc_b),
        .instr_valid_a(instr_valid_a),
        .instr_valid_b(instr_valid_b),
        .instr_a      (instr_a),
        .instr_b      (instr_b),
        .instr_pc_a   (instr_pc_a),
        .instr_pc_b   (instr_pc_b),
        .instr_ready_a(instr_ready_a),
        .instr_ready_b(instr_ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en_a) imem_dout_a <= 32'h1000_0000 + imem_addr_a;
        if (imem_en_b) imem_dout_b <= 32'h2000_0000 + imem_addr_b;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic m, input logic ra, input logic rb,
                                 input logic da, input logic [31:0] pa,
                                 input logic db, input logic [31:0] pb);
        rst           = r;
        mode          = m;
        instr_ready_a = ra;
        instr_ready_b = rb;
        redir_a       = da;
        redir_pc_a    = pa;
        redir_b       = db;
        redir_pc_b    = pb;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Two reset edges, then leaves the bench in the first cycle after reset.
    task automatic doReset(input logic m, input logic ra);
        applyStimulus(1'b1, m, ra, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick;
        tick;
        applyStimulus(1'b0, m, ra, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        $display("[TB] fetch_queue directed test start");

        // Reset values and unified-mode streaming
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick;
        checkOutput("rst_en_a", 32'(imem_en_a), 32'd0);
        checkOutput("rst_en_b", 32'(imem_en_b), 32'd0);
        checkOutput("rst_addr_a", imem_addr_a, 32'd0);
        checkOutput("rst_addr_b", imem_addr_b, 32'd512);
        checkOutput("rst_valid_a", 32'(instr_valid_a), 32'd0);
        checkOutput("rst_instr_a", instr_a, 32'd0);
        checkOutput("rst_pc_a", instr_pc_a, 32'd0);
        checkOutput("rst_valid_b", 32'(instr_valid_b), 32'd0);
        tick;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("first_en_a", 32'(imem_en_a), 32'd1);
        checkOutput("first_valid_a", 32'(instr_valid_a), 32'd0);
        tick;
        checkOutput("second_valid_a", 32'(instr_valid_a), 32'd0);
        checkOutput("second_addr_a", imem_addr_a, 32'd1);
        tick;
        for (int k = 0; k < 6; k++) begin
            checkOutput("stream_valid_a", 32'(instr_valid_a), 32'd1);
            checkOutput("stream_pc_a", instr_pc_a, 32'(k));
            checkOutput("stream_instr_a", instr_a, 32'h1000_0000 + 32'(k));
            checkOutput("unified_valid_b", 32'(instr_valid_b), 32'd0);
            checkOutput("unified_en_b", 32'(imem_en_b), 32'd0);
            tick;
        end

        // Backpressure: FIFO fills to exactly DEPTH, then drains gap-free
        doReset(1'b1, 1'b0);
        enCount = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_en_a) enCount++;
            tick;
        end
        checkOutput("bp_enables", 32'(enCount), 32'd4);
        checkOutput("bp_valid", 32'(instr_valid_a), 32'd1);
        checkOutput("bp_pc", instr_pc_a, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int j = 0; j < 8; j++) begin
            checkOutput("bp_drain_valid", 32'(instr_valid_a), 32'd1);
            checkOutput("bp_drain_pc", instr_pc_a, 32'(j));
            checkOutput("bp_drain_instr", instr_a, 32'h1000_0000 + 32'(j));
            tick;
        end

        // Redirect with three queued entries and one read in flight
        doReset(1'b1, 1'b0);
        tick; tick; tick; tick;
        checkOutput("rd_pre_pc", instr_pc_a, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        checkOutput("rd_cycle_en", 32'(imem_en_a), 32'd0);
        tick;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("rd_next_valid", 32'(instr_valid_a), 32'd0);
        checkOutput("rd_target_en", 32'(imem_en_a), 32'd1);
        checkOutput("rd_target_addr", imem_addr_a, 32'h40);
        tick;
        checkOutput("rd_gap_valid", 32'(instr_valid_a), 32'd0);
        tick;
        checkOutput("rd_head_valid", 32'(instr_valid_a), 32'd1);
        checkOutput("rd_head_pc", instr_pc_a, 32'h40);
        checkOutput("rd_head_instr", instr_a, 32'h1000_0040);
        tick;
        checkOutput("rd_head2_pc", instr_pc_a, 32'h41);

        // Redirect and pop in the same cycle on a full FIFO
        doReset(1'b1, 1'b0);
        tick; tick; tick; tick; tick;
        checkOutput("full_en", 32'(imem_en_a), 32'd0);
        checkOutput("full_pc", instr_pc_a, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        checkOutput("fullrd_en", 32'(imem_en_a), 32'd0);
        tick;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("fullrd_valid", 32'(instr_valid_a), 32'd0);
        checkOutput("fullrd_addr", imem_addr_a, 32'h80);
        tick;
        checkOutput("fullrd_gap_valid", 32'(instr_valid_a), 32'd0);
        tick;
        checkOutput("fullrd_head_pc", instr_pc_a, 32'h80);
        checkOutput("fullrd_head_instr", instr_a, 32'h1000_0080);
        tick;
        checkOutput("fullrd_head2_pc", instr_pc_a, 32'h81);

        // Reset pulse mid-stream, then a mode toggle
        doReset(1'b1, 1'b0);
        tick; tick; tick;
        checkOutput("rp_pre_valid", 32'(instr_valid_a), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("rp_en", 32'(imem_en_a), 32'd0);
        tick;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("rp_valid", 32'(instr_valid_a), 32'd0);
        checkOutput("rp_instr", instr_a, 32'd0);
        checkOutput("rp_pc", instr_pc_a, 32'd0);
        checkOutput("rp_addr_a", imem_addr_a, 32'd0);
        checkOutput("rp_addr_b", imem_addr_b, 32'd512);
        checkOutput("rp_restart_en", 32'(imem_en_a), 32'd1);
        tick; tick;
        checkOutput("rp_head_valid", 32'(instr_valid_a), 32'd1);
        checkOutput("rp_head_pc", instr_pc_a, 32'd0);
        checkOutput("rp_head_instr", instr_a, 32'h1000_0000);
        tick;
        checkOutput("rp_head1_pc", instr_pc_a, 32'd1);
        tick;
        checkOutput("rp_head2_pc", instr_pc_a, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("mt_en_a", 32'(imem_en_a), 32'd0);
        checkOutput("mt_en_b", 32'(imem_en_b), 32'd0);
        tick;
        checkOutput("mt_valid_a", 32'(instr_valid_a), 32'd0);
        checkOutput("mt_valid_b", 32'(instr_valid_b), 32'd0);
        checkOutput("mt_addr_a", imem_addr_a, 32'd0);
        checkOutput("mt_addr_b", imem_addr_b, 32'd512);
        checkOutput("mt_restart_en_b", 32'(imem_en_b), 32'd1);
        tick; tick;
        checkOutput("mt_head_pc_a", instr_pc_a, 32'd0);
        checkOutput("mt_head_valid_b", 32'(instr_valid_b), 32'd1);
        checkOutput("mt_head_pc_b", instr_pc_b, 32'd0);
        checkOutput("mt_head_instr_b", instr_b, 32'h2000_0200);

        // Split mode: independent lanes, lane B redirected mid-stream
        doReset(1'b0, 1'b1);
        expA = 0;
        expB = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, (i % 3 != 0), 1'b0, 32'h0, (i == 10), 32'h10);
            if (i == 1) checkOutput("split_addr_b0", imem_addr_b, 32'd512);
            if (i == 2) checkOutput("split_addr_b1", imem_addr_b, 32'd513);
            if (i == 10) begin
                checkOutput("split_redir_en_b", 32'(imem_en_b), 32'd0);
                expB = 32'h10;
            end else if (instr_valid_b && instr_ready_b) begin
                checkOutput("split_pc_b", instr_pc_b, 32'(expB));
                checkOutput("split_instr_b", instr_b, 32'h2000_0200 + 32'(expB));
                expB++;
            end
            if (instr_valid_a) begin
                checkOutput("split_pc_a", instr_pc_a, 32'(expA));
                checkOutput("split_instr_a", instr_a, 32'h1000_0000 + 32'(expA));
                expA++;
            end
            tick;
        end
        checkOutput("split_count_a", 32'(expA), 32'd18);
        checkOutput("split_next_b", 32'(expB), 32'h16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
